fetch_redirect_unit: RTL
========================

# fetch_redirect_unit

Fetch-side consumer of the 2-bit dynamic branch predictor. It owns the program counter and redirects fetch to the branch target when the predictor says taken for a branch in ID. It carries each prediction down to EX, and on a wrong prediction restores the correct PC and squashes the wrong-path instructions. It sits between IF/ID and ID/EX and drives the predictor's EX-stage prediction input.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- stall_i  in  1  hazard stall; holds PC and IF/ID contents, inserts bubble into EX
- predict_i  in  1  predictor output: 1 = predict taken
- ID_branch_i  in  1  instruction in ID is a conditional branch
- ID_pc_i  in  32  PC of instruction in ID
- ID_imm_i  in  32  sign-extended branch immediate (halfword units)
- EX_resolve_i  in  1  branch in EX has resolved this cycle
- EX_taken_i  in  1  actual outcome of the EX branch (1 = taken)
- pc_o  out  32  current fetch PC
- ID_flush_o  out  1  squash IF/ID register this edge
- EX_flush_o  out  1  squash ID/EX register this edge
- EX_predict_o  out  1  prediction bit of branch in EX (to the predictor)
- mispredict_o  out  1  EX branch was mispredicted
- branch_cnt_o  out  32  resolved branches (BRP_STATS_EN only)
- mispredict_cnt_o  out  32  mispredictions (BRP_STATS_EN only)

## Operation
- Target computation: target = ID_pc_i + (ID_imm_i << 1). Fallthrough = ID_pc_i + 4. Both are modulo 2^32, and wrap-around is silent.
- EX record: registers rec_valid, rec_pred, rec_recover[31:0]. rec_recover holds fallthrough if predicted taken, otherwise target.
- EX_predict_o = rec_pred.
- mispredict_o = EX_resolve_i & rec_valid & (rec_pred != EX_taken_i). If EX_resolve_i is asserted with rec_valid = 0, the unit ignores it.
- Next-PC priority, highest first:
  1. mispredict: next PC = rec_recover. ID_flush_o = 1 and EX_flush_o = 1. The record is cleared (rec_valid <= 0). Mispredict overrides stall_i.
  2. stall_i: PC is held and the record is loaded with rec_valid <= 0 (bubble). No ID redirect happens even if ID holds a predicted-taken branch; the redirect occurs once the stall releases.
  3. ID_branch_i & predict_i: next PC = target and ID_flush_o = 1, which squashes the sequential instruction fetched behind the branch. The record is loaded with {1, 1, fallthrough}.
  4. ID_branch_i & ~predict_i: next PC = pc_o + 4. The record is loaded with {1, 0, target}.
  5. Otherwise: next PC = pc_o + 4 and rec_valid <= 0.
- A mispredict in EX and a branch in ID in the same cycle: EX wins. The ID branch is on the wrong path, so it is never recorded or counted.
- Reset: pc_o = RESET_PC, rec_valid = 0, rec_pred = 0, rec_recover = 0. Counters are 0. All flush and mispredict outputs are 0 because rec_valid = 0.

## Timing
- pc_o and the EX record are registered and update on the rising edge of clk_i.
- ID_flush_o, EX_flush_o and mispredict_o are combinational in the cycle the condition is true. The redirected pc_o appears after the next edge.
- Predicted-taken penalty is 1 bubble: one squashed IF/ID slot.
- Mispredict penalty is 2 bubbles: IF/ID and ID/EX are both squashed.
- Reset assertion mid-operation clears all state immediately, regardless of clock. The first fetch after release is RESET_PC.

## Configuration
- BRP_STATS_EN defined:
  - branch_cnt_o increments on every EX_resolve_i & rec_valid.
  - mispredict_cnt_o increments on every mispredict_o.
  - Both are saturating at 32'hFFFF_FFFF, registered, and reset to 0.
- BRP_STATS_EN undefined: both count ports are tied to 0 and no counter flops are built.

## Test plan
- Reset with RESET_PC = 0x100, then release: pc_o = 0x100, then 0x104, 0x108. All flushes stay 0.
- ID branch at 0x108 with imm = 8, predict_i = 1:
  - ID_flush_o = 1 and next pc_o = 0x118.
  - In EX, EX_predict_o = 1. With EX_taken_i = 1, there is no mispredict.
- Same branch but EX_taken_i = 0 at resolve:
  - mispredict_o = 1, ID_flush_o = 1 and EX_flush_o = 1.
  - Next pc_o = 0x10C.
  - Counters read 1 branch and 1 mispredict.
- ID branch at 0x200 with imm = -4, predict_i = 0, resolve taken:
  - Next pc_o = 0x1F8 after mispredict.
  - Target wraps correctly for 0x0 with imm = -2, giving 0xFFFF_FFFC.
- Mispredict in EX concurrent with stall_i = 1 and a predicted-taken branch in ID:
  - pc_o goes to rec_recover and both flushes assert.
  - The ID branch is not recorded and not counted.
- Assert rst_i low mid-cycle while rec_valid = 1: pc_o returns to RESET_PC asynchronously, rec_valid = 0 and mispredict_o = 0.

Source files
------------

// File: rtl/fetch_redirect_unit.sv
// Fetch PC owner with ID-stage taken-branch redirect and EX-stage mispredict recovery.
// Optional resolved-branch / mispredict statistics counters are built when BRP_STATS_EN is defined.
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        predict_i,
  input  logic        ID_branch_i,
  input  logic [31:0] ID_pc_i,
  input  logic [31:0] ID_imm_i,
  input  logic        EX_resolve_i,
  input  logic        EX_taken_i,
  output logic [31:0] pc_o,
  output logic        ID_flush_o,
  output logic        EX_flush_o,
  output logic        EX_predict_o,
  output logic        mispredict_o,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] mispredict_cnt_o
);

  logic [31:0] pc_q, pc_d;
  logic        rec_valid_q, rec_valid_d;
  logic        rec_pred_q, rec_pred_d;
  logic [31:0] rec_recover_q, rec_recover_d;

  logic [31:0] target;
  logic [31:0] fallthrough;
  logic        mispredict;
  logic        resolved;
  logic        id_flush;
  logic        ex_flush;

  // Immediate is in halfword units; both sums wrap silently.
  assign target      = ID_pc_i + {ID_imm_i[30:0], 1'b0};
  assign fallthrough = ID_pc_i + 32'd4;
  assign resolved    = EX_resolve_i & rec_valid_q;
  assign mispredict  = resolved & (rec_pred_q != EX_taken_i);

  always_comb begin
    pc_d          = pc_q + 32'd4;
    rec_valid_d   = 1'b0;
    rec_pred_d    = rec_pred_q;
    rec_recover_d = rec_recover_q;
    id_flush      = 1'b0;
    ex_flush      = 1'b0;
    if (mispredict) begin
      // The ID instruction is on the wrong path, so it is neither recorded nor counted.
      pc_d     = rec_recover_q;
      id_flush = 1'b1;
      ex_flush = 1'b1;
    end else if (stall_i) begin
      pc_d = pc_q;
    end else if (ID_branch_i && predict_i) begin
      pc_d          = target;
      id_flush      = 1'b1;
      rec_valid_d   = 1'b1;
      rec_pred_d    = 1'b1;
      rec_recover_d = fallthrough;
    end else if (ID_branch_i) begin
      rec_valid_d   = 1'b1;
      rec_pred_d    = 1'b0;
      rec_recover_d = target;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q          <= RESET_PC;
      rec_valid_q   <= 1'b0;
      rec_pred_q    <= 1'b0;
      rec_recover_q <= 32'h0000_0000;
    end else begin
      pc_q          <= pc_d;
      rec_valid_q   <= rec_valid_d;
      rec_pred_q    <= rec_pred_d;
      rec_recover_q <= rec_recover_d;
    end
  end

  assign pc_o         = pc_q;
  assign ID_flush_o   = id_flush;
  assign EX_flush_o   = ex_flush;
  assign EX_predict_o = rec_pred_q;
  assign mispredict_o = mispredict;

`ifdef BRP_STATS_EN
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

  // Saturating counters: they stick at all-ones rather than wrapping.
  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (resolved && (branch_cnt_q != 32'hFFFF_FFFF)) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
    end
    if (mispredict && (mispredict_cnt_q != 32'hFFFF_FFFF)) begin
      mispredict_cnt_d = mispredict_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      branch_cnt_q     <= 32'h0000_0000;
      mispredict_cnt_q <= 32'h0000_0000;
    end else begin
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;
`else
  assign branch_cnt_o     = 32'h0000_0000;
  assign mispredict_cnt_o = 32'h0000_0000;
`endif

endmodule
